// File: rtl/lcd_writer_pkg.sv
// +----------------------------------------------------------------------------+
// | lcd_writer_pkg : shared types, command codes and helpers for lcd_writer    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package lcd_writer_pkg;

  localparam int ENTRY_W = 9;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_PULSE    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_IDLE     = 3'd5
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } entry_t;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Clear and home need the long execution wait on the panel.
  function automatic logic is_slow(input entry_t e);
    return !e.rs && (e.data == CMD_CLEAR || e.data == CMD_HOME);
  endfunction

  function automatic logic [5:0] next_col(input entry_t e, input logic [5:0] col);
    if (e.rs)                                          return col + 6'd1;
    else if (e.data == CMD_CLEAR || e.data == CMD_HOME) return 6'd0;
    else if (e.data[7])                                return {1'b0, e.data[6], e.data[3:0]};
    else                                               return col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_fifo.sv
// +----------------------------------------------------------------------------+
// | lcd_fifo : request FIFO; push ignored when full, pop ignored when empty    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_writer.sv
// +----------------------------------------------------------------------------+
// | lcd_writer : buffers processor LCD writes and drives an HD44780 panel      |
// |              (8-bit mode). Define LCD_AUTOWRAP_EN for automatic line wrap. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_writer
  import lcd_writer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int POWERON_CYC = 750000,
  parameter int SETUP_CYC   = 4,
  parameter int EPULSE_CYC  = 16,
  parameter int CMD_CYC     = 2000,
  parameter int CLR_CYC     = 82000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lcd_write,
  input  logic [31:0] lcd_data,
  output logic        fifo_full,
  output logic        overflow,
  output logic        lcd_idle,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_db,
  output logic        lcd_on,
  output logic        lcd_blon
);

  localparam logic [19:0] PWR_LD   = 20'(POWERON_CYC - 1);
  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] PULSE_LD = 20'(EPULSE_CYC - 1);
  localparam logic [19:0] CMD_LD   = 20'(CMD_CYC - 1);
  localparam logic [19:0] CLR_LD   = 20'(CLR_CYC - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        init_done_q, init_done_d;
  entry_t      cur_q, cur_d;
  logic        on_q, overflow_q;
  logic        pop, fifo_empty;
  entry_t      head;
  logic        unused_data_bits;

  assign unused_data_bits = ^lcd_data[31:9];

  lcd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (lcd_write),
    .wdata_i ({~lcd_data[8], lcd_data[7:0]}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

`ifdef LCD_AUTOWRAP_EN
  logic [5:0] col_q, col_d;
  logic       wrap_pend_q, wrap_pend_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    cur_d       = cur_q;
    pop         = 1'b0;
`ifdef LCD_AUTOWRAP_EN
    col_d       = col_q;
    wrap_pend_d = wrap_pend_q;
`endif
    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end else cnt_d = cnt_q - 20'd1;
      end
      ST_INIT: begin
        cur_d.rs   = 1'b0;
        cur_d.data = init_rom(idx_q[1:0]);
        idx_d      = idx_q + 3'd1;
        cnt_d      = SETUP_LD;
        state_d    = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = PULSE_LD;
          state_d = ST_PULSE;
        end else cnt_d = cnt_q - 20'd1;
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = is_slow(cur_q) ? CLR_LD : CMD_LD;
          state_d = ST_HOLD;
        end else cnt_d = cnt_q - 20'd1;
      end
      ST_HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - 20'd1;
        else if (init_done_q) state_d = ST_IDLE;
        else if (idx_q == 3'd4) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else state_d = ST_INIT;
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
`ifdef LCD_AUTOWRAP_EN
          // The wrap command is slipped in ahead of the character, which stays queued.
          if (head.rs && !wrap_pend_q && (col_q == 6'd16 || col_q == 6'd32)) begin
            cur_d.rs    = 1'b0;
            cur_d.data  = (col_q == 6'd16) ? CMD_LINE2 : CMD_LINE1;
            col_d       = (col_q == 6'd16) ? 6'd16 : 6'd0;
            wrap_pend_d = 1'b1;
          end else begin
            pop         = 1'b1;
            cur_d       = head;
            col_d       = next_col(head, col_q);
            wrap_pend_d = 1'b0;
          end
`else
          pop   = 1'b1;
          cur_d = head;
`endif
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PWR_WAIT;
      cnt_q       <= PWR_LD;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      cur_q       <= '0;
      on_q        <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
      col_q       <= '0;
      wrap_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      cur_q       <= cur_d;
      on_q        <= 1'b1;
      if (lcd_write && fifo_full) overflow_q <= 1'b1;
`ifdef LCD_AUTOWRAP_EN
      col_q       <= col_d;
      wrap_pend_q <= wrap_pend_d;
`endif
    end
  end

  assign overflow = overflow_q;
  assign lcd_idle = init_done_q && fifo_empty && (state_q == ST_IDLE);
  assign lcd_rs   = cur_q.rs;
  assign lcd_db   = cur_q.data;
  assign lcd_en   = (state_q == ST_PULSE);
  assign lcd_rw   = 1'b0;
  assign lcd_on   = on_q;
  assign lcd_blon = on_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_writer.sv
// +----------------------------------------------------------------------------+
// | tb_lcd_writer : directed self-checking bench for lcd_writer                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lcd_writer;

  localparam int POWERON = 20;
  localparam int SETUP   = 2;
  localparam int EPULSE  = 3;
  localparam int CMDW    = 10;
  localparam int CLRW    = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lcd_write = 1'b0;
  logic [31:0] lcd_data = '0;
  logic        fifo_full, overflow, lcd_idle, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
  logic [7:0]  lcd_db;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_writer #(
    .FIFO_DEPTH(8), .POWERON_CYC(POWERON), .SETUP_CYC(SETUP),
    .EPULSE_CYC(EPULSE), .CMD_CYC(CMDW), .CLR_CYC(CLRW)
  ) dut (
    .clock(clock), .reset(reset), .lcd_write(lcd_write), .lcd_data(lcd_data),
    .fifo_full(fifo_full), .overflow(overflow), .lcd_idle(lcd_idle),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_db(lcd_db),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon)
  );

  always #5 clock = ~clock;

  // Pulse recorder: cycle index counts negedge samples since reset release.
  int         cyc = 0;
  logic       en_prev = 1'b0;
  int         wcount = 0;
  logic [8:0] pulses[$];
  int         rises[$];
  int         falls[$];
  int         widths[$];

  always @(negedge clock) begin
    if (!reset) begin
      cyc     = 0;
      en_prev = 1'b0;
    end else begin
      cyc++;
      if (lcd_en && !en_prev) begin
        pulses.push_back({lcd_rs, lcd_db});
        rises.push_back(cyc);
        wcount = 1;
      end else if (lcd_en) wcount++;
      else if (en_prev) begin
        falls.push_back(cyc);
        widths.push_back(wcount);
      end
      en_prev = lcd_en;
    end
  end

  task automatic clear_log();
    pulses.delete(); rises.delete(); falls.delete(); widths.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    lcd_write = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    clear_log();
    reset = 1'b1;
  endtask

  task automatic write_word(input logic [31:0] w);
    lcd_write = 1'b1;
    lcd_data  = w;
    @(negedge clock); #1;
    lcd_write = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock); #1;
      if (lcd_idle) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    bit ok; int at;
    logic [8:0] exp_init [4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
    reset = 1'b0;
    repeat (3) @(negedge clock); #1;
    n_checks++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_on, lcd_blon, fifo_full, overflow, lcd_idle} !== 15'd0)
      $display("FAIL reset_outputs: got en=%b rs=%b rw=%b db=%h on=%b blon=%b full=%b ovf=%b idle=%b, want all 0",
               lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_on, lcd_blon, fifo_full, overflow, lcd_idle);
    else n_pass++;
    clear_log();
    reset = 1'b1;
    @(negedge clock); #1;
    n_checks++;
    if ({lcd_on, lcd_blon, lcd_rw, lcd_en} !== 4'b1100)
      $display("FAIL power_on: got on=%b blon=%b rw=%b en=%b, want 1 1 0 0", lcd_on, lcd_blon, lcd_rw, lcd_en);
    else n_pass++;
    wait_idle(2000, ok, at);
    n_checks++;
    if (!ok) $display("FAIL init_idle_timeout: idle not seen, want idle within 2000 cycles");
    else n_pass++;
    n_checks++;
    if (pulses.size() != 4) $display("FAIL init_pulse_count: got %0d want 4", pulses.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= pulses.size() || pulses[i] !== exp_init[i])
        $display("FAIL init_pulse_%0d: got %h want %h", i, (i < pulses.size()) ? pulses[i] : 9'h1FF, exp_init[i]);
      else n_pass++;
    end
    n_checks++;
    if (rises.size() < 1 || rises[0] != POWERON + 1 + SETUP)
      $display("FAIL first_rise_cycle: got %0d want %0d", (rises.size() > 0) ? rises[0] : -1, POWERON + 1 + SETUP);
    else n_pass++;
    n_checks++;
    if (widths.size() != 4 || widths[0] != EPULSE || widths[3] != EPULSE)
      $display("FAIL init_width: got n=%0d w0=%0d want 4 pulses of %0d", widths.size(),
               (widths.size() > 0) ? widths[0] : -1, EPULSE);
    else n_pass++;
    n_checks++;
    if (falls.size() < 4 || at - falls[3] != CLRW)
      $display("FAIL clear_gap: got %0d want %0d", (falls.size() >= 4) ? at - falls[3] : -1, CLRW);
    else n_pass++;
  endtask

  task automatic test_char();
    bit ok; int at; int c_push;
    clear_log();
    write_word(32'h0000_0041);
    c_push = cyc;
    wait_idle(500, ok, at);
    n_checks++;
    if (!ok) $display("FAIL char_idle_timeout: idle not seen, want idle within 500 cycles");
    else n_pass++;
    n_checks++;
    if (pulses.size() != 1 || pulses[0] !== 9'h141)
      $display("FAIL char_pulse: got n=%0d first=%h want 1 pulse 141", pulses.size(),
               (pulses.size() > 0) ? pulses[0] : 9'h000);
    else n_pass++;
    n_checks++;
    if (widths.size() != 1 || widths[0] != EPULSE)
      $display("FAIL char_width: got %0d want %0d", (widths.size() > 0) ? widths[0] : -1, EPULSE);
    else n_pass++;
    n_checks++;
    if (rises.size() != 1 || rises[0] - c_push != SETUP + 1)
      $display("FAIL char_latency: got %0d want %0d", (rises.size() > 0) ? rises[0] - c_push : -1, SETUP + 1);
    else n_pass++;
    n_checks++;
    if (falls.size() != 1 || at - falls[0] != CMDW)
      $display("FAIL char_hold: got %0d want %0d", (falls.size() > 0) ? at - falls[0] : -1, CMDW);
    else n_pass++;
  endtask

  task automatic test_overflow();
    bit ok; int at;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      lcd_write = 1'b1;
      lcd_data  = 32'h0000_0030 + 32'(i);
      @(negedge clock); #1;
      if (i == 6) begin
        n_checks++;
        if (fifo_full !== 1'b0) $display("FAIL full_early: got %b want 0", fifo_full);
        else n_pass++;
      end
      if (i == 7) begin
        n_checks++;
        if ({fifo_full, overflow} !== 2'b10)
          $display("FAIL full_at_8: got full=%b ovf=%b want 1 0", fifo_full, overflow);
        else n_pass++;
      end
    end
    lcd_write = 1'b0;
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL overflow_set: got %b want 1", overflow);
    else n_pass++;
    wait_idle(3000, ok, at);
    n_checks++;
    if (!ok || pulses.size() != 12)
      $display("FAIL ovf_pulse_count: got %0d want 12 (idle seen=%b)", pulses.size(), ok);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (4 + k >= pulses.size() || pulses[4+k] !== (9'h130 + 9'(k)))
        $display("FAIL ovf_byte_%0d: got %h want %h", k, (4 + k < pulses.size()) ? pulses[4+k] : 9'h000,
                 9'h130 + 9'(k));
      else n_pass++;
    end
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b want 1", overflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    bit ok; int at; bit seen;
    write_word(32'h0000_0078);
    write_word(32'h0000_0079);
    write_word(32'h0000_007A);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (lcd_en) begin seen = 1'b1; break; end
      @(negedge clock); #1;
    end
    n_checks++;
    if (!seen) $display("FAIL midpulse_en_timeout: en not seen, want en within 50 cycles");
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({lcd_en, lcd_on, lcd_rs, lcd_db, lcd_idle, overflow} !== 13'd0)
      $display("FAIL midpulse_async: got en=%b on=%b rs=%b db=%h idle=%b ovf=%b want all 0",
               lcd_en, lcd_on, lcd_rs, lcd_db, lcd_idle, overflow);
    else n_pass++;
    @(negedge clock); #1;
    clear_log();
    reset = 1'b1;
    wait_idle(2000, ok, at);
    n_checks++;
    if (!ok || pulses.size() != 4 || pulses[0] !== 9'h038 || pulses[3] !== 9'h001)
      $display("FAIL midpulse_replay: got n=%0d first=%h want 4 init pulses only (idle seen=%b)",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : 9'h000, ok);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok; int at; bit room;
    logic [8:0] exp[$];
    apply_reset();
    wait_idle(2000, ok, at);
    clear_log();
    for (int i = 0; i < 17; i++) begin
      room = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (!fifo_full) begin room = 1'b1; break; end
        @(negedge clock); #1;
      end
      if (!room) begin
        n_checks++;
        $display("FAIL wrap_full_timeout: fifo stayed full, want space within 200 cycles");
      end
      write_word(32'h0000_0041 + 32'(i));
    end
    for (int i = 0; i < 16; i++) exp.push_back(9'h141 + 9'(i));
`ifdef LCD_AUTOWRAP_EN
    exp.push_back(9'h0C0);
`endif
    exp.push_back(9'h151);
    wait_idle(3000, ok, at);
    n_checks++;
    if (!ok || pulses.size() != exp.size())
      $display("FAIL wrap_count: got %0d want %0d (idle seen=%b)", pulses.size(), exp.size(), ok);
    else n_pass++;
    for (int i = 15; i < exp.size(); i++) begin
      n_checks++;
      if (i >= pulses.size() || pulses[i] !== exp[i])
        $display("FAIL wrap_pulse_%0d: got %h want %h", i, (i < pulses.size()) ? pulses[i] : 9'h000, exp[i]);
      else n_pass++;
    end
    clear_log();
    write_word(32'h0000_0101);
    write_word(32'h0000_0052);
    wait_idle(1000, ok, at);
    n_checks++;
    if (!ok || pulses.size() != 2 || pulses[0] !== 9'h001 || pulses[1] !== 9'h152)
      $display("FAIL clear_then_char: got n=%0d p0=%h want 001 then 152 (idle seen=%b)",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : 9'h000, ok);
    else n_pass++;
    n_checks++;
    if (falls.size() < 1 || rises.size() < 2 || rises[1] - falls[0] != CLRW + 1 + SETUP)
      $display("FAIL clear_hold: got %0d want %0d",
               (falls.size() >= 1 && rises.size() >= 2) ? rises[1] - falls[0] : -1, CLRW + 1 + SETUP);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_char();
    test_overflow();
    test_reset_mid_pulse();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 2 ms");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
